// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths and byte-lane helpers for the data RAM pipe
package mem_pkg;

    localparam int DEF_ADDR_W = 17;
    localparam int DEF_DATA_W = 32;
    localparam int BE_W       = DEF_DATA_W / 8;

    function automatic logic [7:0] lane_mask(input logic be);
        return {8{be}};
    endfunction

endpackage

// File: rtl/rsp_fifo.sv
// rtl/rsp_fifo.sv - small synchronous FIFO holding {err, rdata} responses
module rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 33,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign do_pop     = pop_i && !empty_o;
    // A push into a full FIFO is only legal when the head leaves on the same edge.
    assign do_push    = push_i && (!full_o || do_pop);
    assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ram_data_pipe.sv
// rtl/ram_data_pipe.sv - handshaked data RAM with byte enables, 1/2-cycle read latency and skid FIFO
module ram_data_pipe
    import mem_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = 98304,
    parameter int LAT       = 1,
    parameter     INIT_FILE = "ram_data.mem"
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam int BE_N  = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(LAT + 2);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] wmask;
    logic [IDX_W-1:0]  idx;
    logic              acc, pop, in_range;
    logic [CW-1:0]     credits_q, credits_d;

    logic              s1_valid_q, s1_err_q;
    logic [DATA_W-1:0] s1_rdata_q;
    logic              push;
    logic [DATA_W:0]   push_data, head;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;

    assign pop       = rsp_valid && rsp_ready;
    assign req_ready = (credits_q < CW'(LAT + 1)) || pop;
    assign acc       = req_valid && req_ready;
    assign in_range  = 32'(req_addr) < 32'(DEPTH);
    assign idx       = req_addr[IDX_W-1:0];

    for (genvar i = 0; i < BE_N; i++) begin : g_lane
        assign wmask[8*i +: 8] = lane_mask(req_be[i]);
    end

    // Read-first: the pre-write word is captured on the same edge the write lands.
    always_ff @(posedge clk) begin
        if (acc) begin
            s1_rdata_q <= in_range ? mem_q[idx] : '0;
            if (req_we && in_range) begin
                mem_q[idx] <= (mem_q[idx] & ~wmask) | (req_wdata & wmask);
            end
        end
    end

    always_comb begin
        credits_d = credits_q;
        case ({acc, pop})
            2'b10:   credits_d = credits_q + 1'b1;
            2'b01:   credits_d = credits_q - 1'b1;
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_err_q   <= 1'b0;
            credits_q  <= '0;
        end else begin
            s1_valid_q <= acc;
            if (acc) begin
                s1_err_q <= !in_range;
            end
            credits_q <= credits_d;
        end
    end

    if (LAT == 2) begin : g_lat2
        logic              s2_valid_q, s2_err_q;
        logic [DATA_W-1:0] s2_rdata_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_valid_q <= 1'b0;
                s2_err_q   <= 1'b0;
                s2_rdata_q <= '0;
            end else begin
                s2_valid_q <= s1_valid_q;
                s2_err_q   <= s1_err_q;
                s2_rdata_q <= s1_rdata_q;
            end
        end

        assign push      = s2_valid_q;
        assign push_data = {s2_err_q, s2_rdata_q};
    end else begin : g_lat1
        assign push      = s1_valid_q;
        assign push_data = {s1_err_q, s1_rdata_q};
    end

    rsp_fifo #(
        .DEPTH(LAT + 1),
        .WIDTH(DATA_W + 1)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_data_i(push_data),
        .pop_i      (pop),
        .pop_data_o (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    assign rsp_valid            = !fifo_empty;
    assign {rsp_err, rsp_rdata} = head;

    // Credits bound everything downstream, so the FIFO can never be pushed while full.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && fifo_full && !pop));
    a_credit_cover: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_count <= credits_q);

endmodule

// File: tb/tb_ram_data_pipe.sv
// tb/tb_ram_data_pipe.sv - randomized self-checking bench for ram_data_pipe at LAT=1 and LAT=2
module tb_ram_data_pipe;

    typedef struct {
        int          d;
        logic [31:0] data;
        logic        err;
        bit          known;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [3:0]  req_be    [2];
    logic [7:0]  req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int          pass_cnt = 0;
    int          total_cnt = 0;
    rsp_t        exp_q[$];
    rsp_t        obs_q[$];
    rsp_t        mon_r;
    logic [31:0] mem_m [2][256];
    logic [3:0]  kb_m  [2][256];
    int          depth_m [2] = '{16, 40};
    int          lat_m   [2] = '{1, 2};
    int          mon_a;

    always #5 clk = ~clk;

    ram_data_pipe #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .LAT(1), .INIT_FILE("")) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_be(req_be[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    ram_data_pipe #(.ADDR_W(8), .DATA_W(32), .DEPTH(40), .LAT(2), .INIT_FILE("")) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_be(req_be[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    // Reference model: observe handshakes mid-cycle, record popped responses and
    // predict each accepted request from a word array with per-byte known flags.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (rsp_valid[d] && rsp_ready[d]) begin
                    mon_r.d = d; mon_r.data = rsp_rdata[d]; mon_r.err = rsp_err[d]; mon_r.known = 1'b1;
                    obs_q.push_back(mon_r);
                end
                if (req_valid[d] && req_ready[d]) begin
                    mon_a = int'(req_addr[d]);
                    mon_r.d = d;
                    if (mon_a >= depth_m[d]) begin
                        mon_r.data = 32'h0; mon_r.err = 1'b1; mon_r.known = 1'b1;
                    end else begin
                        mon_r.data = mem_m[d][mon_a]; mon_r.err = 1'b0;
                        mon_r.known = (kb_m[d][mon_a] == 4'hF);
                        if (req_we[d]) begin
                            for (int b = 0; b < 4; b++) begin
                                if (req_be[d][b]) begin
                                    mem_m[d][mon_a][8*b +: 8] = req_wdata[d][8*b +: 8];
                                    kb_m[d][mon_a][b] = 1'b1;
                                end
                            end
                        end
                    end
                    exp_q.push_back(mon_r);
                end
            end
        end
    end

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input int d, input bit we, input logic [3:0] be,
                         input logic [7:0] a, input logic [31:0] w);
        req_valid[d] = 1'b1; req_we[d] = we; req_be[d] = be; req_addr[d] = a; req_wdata[d] = w;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (req_ready[d]) break;
        end
        if (!req_ready[d]) begin
            total_cnt++;
            $display("FAIL issue_timeout dut%0d addr %0d: req_ready stayed 0, required 1", d, a);
        end
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            total_cnt++;
            if (rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 32'h0 || rsp_err[d] !== 1'b0)
                $display("FAIL reset_outputs dut%0d: valid=%b rdata=%h err=%b, required 0/0/0",
                         d, rsp_valid[d], rsp_rdata[d], rsp_err[d]);
            else pass_cnt++;
        end
        settle(2);
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total_cnt++;
            if (req_ready[d] !== 1'b1)
                $display("FAIL reset_ready dut%0d: got %b, required 1", d, req_ready[d]);
            else pass_cnt++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        issue(0, 1'b1, 4'hF, 8'd5, 32'h01020304);
        issue(0, 1'b1, 4'hF, 8'd5, 32'hDEADBEEF);
        settle(4);
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 8'd5;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        total_cnt++;
        if (rsp_valid[0] !== 1'b0) $display("FAIL lat1_early: rsp_valid=%b on accept edge, required 0", rsp_valid[0]);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'hDEADBEEF || rsp_err[0] !== 1'b0)
            $display("FAIL lat1_read: valid=%b rdata=%h err=%b, required 1/deadbeef/0",
                     rsp_valid[0], rsp_rdata[0], rsp_err[0]);
        else pass_cnt++;
        settle(4);
        total_cnt++;
        if (obs_q.size() != 3 || obs_q[1].data !== 32'h01020304 || obs_q[1].err !== 1'b0)
            $display("FAIL write_old_word: n=%0d rdata=%h, required 3/01020304", obs_q.size(), obs_q[1].data);
        else pass_cnt++;
        total_cnt++;
        if (obs_q.size() != exp_q.size()) $display("FAIL wr_count: got %0d, required %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total_cnt++;
            if (obs_q[i].d != exp_q[i].d || obs_q[i].err !== exp_q[i].err ||
                (exp_q[i].known && obs_q[i].data !== exp_q[i].data))
                $display("FAIL wr_rsp%0d: rdata=%h err=%b, required %h/%b", i, obs_q[i].data,
                         obs_q[i].err, exp_q[i].data, exp_q[i].err);
            else pass_cnt++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_byte_enable();
        issue(0, 1'b1, 4'hF, 8'd7, 32'h11223344);
        issue(0, 1'b1, 4'h5, 8'd7, 32'hAABBCCDD);
        issue(0, 1'b0, 4'h0, 8'd7, 32'h0);
        settle(4);
        total_cnt++;
        if (obs_q.size() != 3 || obs_q[1].data !== 32'h11223344 || obs_q[2].data !== 32'h11BB33DD)
            $display("FAIL byte_enable: n=%0d old=%h new=%h, required 3/11223344/11bb33dd",
                     obs_q.size(), obs_q[1].data, obs_q[2].data);
        else pass_cnt++;
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_out_of_range();
        issue(0, 1'b1, 4'hF, 8'd4, 32'h44444444);
        issue(0, 1'b1, 4'hF, 8'd20, 32'hFFFFFFFF);
        issue(0, 1'b0, 4'h0, 8'd20, 32'h0);
        issue(0, 1'b0, 4'h0, 8'd4, 32'h0);
        settle(4);
        total_cnt++;
        if (obs_q.size() != 4) $display("FAIL oor_count: got %0d, required 4", obs_q.size());
        else pass_cnt++;
        for (int i = 1; i < 3 && i < obs_q.size(); i++) begin
            total_cnt++;
            if (obs_q[i].err !== 1'b1 || obs_q[i].data !== 32'h0)
                $display("FAIL oor_rsp%0d: err=%b rdata=%h, required 1/00000000", i, obs_q[i].err, obs_q[i].data);
            else pass_cnt++;
        end
        total_cnt++;
        if (obs_q[3].err !== 1'b0 || obs_q[3].data !== 32'h44444444)
            $display("FAIL oor_alias: err=%b rdata=%h, required 0/44444444", obs_q[3].err, obs_q[3].data);
        else pass_cnt++;
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        int          acc;
        logic [31:0] held;
        for (int a = 0; a < 3; a++) issue(1, 1'b1, 4'hF, 8'(a), $urandom);
        settle(5);
        rsp_ready[1] = 1'b0;
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 8'd0;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (req_ready[1]) acc++;
            @(posedge clk); #1;
            req_addr[1] = 8'(acc % 3);
        end
        total_cnt++;
        if (acc != 3) $display("FAIL bp_accepts: got %0d, required 3", acc);
        else pass_cnt++;
        total_cnt++;
        if (req_ready[1] !== 1'b0) $display("FAIL bp_ready_low: got %b, required 0", req_ready[1]);
        else pass_cnt++;
        held = rsp_rdata[1];
        settle(1);
        total_cnt++;
        if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== held)
            $display("FAIL bp_hold: valid=%b rdata=%h, required 1/%h", rsp_valid[1], rsp_rdata[1], held);
        else pass_cnt++;
        req_valid[1] = 1'b0;
        rsp_ready[1] = 1'b1;
        #1;
        total_cnt++;
        if (req_ready[1] !== 1'b1) $display("FAIL bp_ready_on_pop: got %b, required 1", req_ready[1]);
        else pass_cnt++;
        settle(8);
        total_cnt++;
        if (obs_q.size() != exp_q.size() || obs_q.size() != 6)
            $display("FAIL bp_count: got %0d, required %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total_cnt++;
            if (obs_q[i].d != exp_q[i].d || obs_q[i].err !== exp_q[i].err ||
                (exp_q[i].known && obs_q[i].data !== exp_q[i].data))
                $display("FAIL bp_rsp%0d: rdata=%h err=%b, required %h/%b", i, obs_q[i].data,
                         obs_q[i].err, exp_q[i].data, exp_q[i].err);
            else pass_cnt++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_stream(input int d);
        int drops, first_k, bad;
        for (int a = 0; a < depth_m[d]; a++) issue(d, 1'b1, 4'hF, 8'(a), $urandom);
        settle(6);
        obs_q.delete(); exp_q.delete();
        drops = 0; first_k = -1;
        for (int k = 0; k < 100; k++) begin
            req_valid[d] = 1'b1;
            req_we[d]    = ($urandom_range(3, 0) == 0);
            req_be[d]    = 4'($urandom);
            req_addr[d]  = 8'($urandom_range(depth_m[d] + 7, 0));
            req_wdata[d] = $urandom;
            @(negedge clk);
            if (!req_ready[d]) drops++;
            if (rsp_valid[d] && first_k < 0) first_k = k;
            @(posedge clk); #1;
        end
        req_valid[d] = 1'b0;
        total_cnt++;
        if (drops != 0) $display("FAIL stream%0d_ready: %0d stalls, required 0", d, drops);
        else pass_cnt++;
        total_cnt++;
        if (first_k != lat_m[d] + 1) $display("FAIL stream%0d_latency: first valid at %0d, required %0d", d, first_k, lat_m[d] + 1);
        else pass_cnt++;
        settle(10);
        total_cnt++;
        if (obs_q.size() != 100 || exp_q.size() != 100)
            $display("FAIL stream%0d_count: got %0d/%0d, required 100", d, obs_q.size(), exp_q.size());
        else pass_cnt++;
        bad = 0;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            if (obs_q[i].d != exp_q[i].d || obs_q[i].err !== exp_q[i].err ||
                (exp_q[i].known && obs_q[i].data !== exp_q[i].data)) begin
                if (bad < 4) $display("FAIL stream%0d_rsp%0d: rdata=%h err=%b, required %h/%b", d, i,
                                      obs_q[i].data, obs_q[i].err, exp_q[i].data, exp_q[i].err);
                bad++;
            end
        end
        total_cnt++;
        if (bad != 0) $display("FAIL stream%0d_data: %0d bad responses, required 0", d, bad);
        else pass_cnt++;
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [31:0] v9, v11;
        v9 = $urandom; v11 = $urandom;
        rsp_ready[1] = 1'b0;
        issue(1, 1'b1, 4'hF, 8'd9, v9);
        issue(1, 1'b0, 4'h0, 8'd9, 32'h0);
        settle(3);
        total_cnt++;
        if (rsp_valid[1] !== 1'b1) $display("FAIL rmid_buffered: valid=%b, required 1", rsp_valid[1]);
        else pass_cnt++;
        issue(1, 1'b1, 4'hF, 8'd11, v11);
        #1 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (rsp_valid[1] !== 1'b0 || rsp_rdata[1] !== 32'h0 || rsp_err[1] !== 1'b0)
            $display("FAIL rmid_flush: valid=%b rdata=%h err=%b, required 0/0/0",
                     rsp_valid[1], rsp_rdata[1], rsp_err[1]);
        else pass_cnt++;
        obs_q.delete(); exp_q.delete();
        settle(2);
        rst_n = 1'b1;
        rsp_ready[1] = 1'b1;
        settle(6);
        total_cnt++;
        if (obs_q.size() != 0) $display("FAIL rmid_stale: %0d responses after reset, required 0", obs_q.size());
        else pass_cnt++;
        issue(1, 1'b0, 4'h0, 8'd11, 32'h0);
        issue(1, 1'b0, 4'h0, 8'd9, 32'h0);
        settle(6);
        total_cnt++;
        if (obs_q.size() != 2 || obs_q[0].data !== v11 || obs_q[1].data !== v9)
            $display("FAIL rmid_commit: n=%0d rd11=%h rd9=%h, required 2/%h/%h",
                     obs_q.size(), obs_q[0].data, obs_q[1].data, v11, v9);
        else pass_cnt++;
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_be[d] = 4'h0;
            req_addr[d] = 8'h0; req_wdata[d] = 32'h0; rsp_ready[d] = 1'b1;
            for (int a = 0; a < 256; a++) kb_m[d][a] = 4'h0;
        end
        test_reset();
        test_write_read();
        test_byte_enable();
        test_out_of_range();
        test_backpressure();
        test_stream(0);
        test_stream(1);
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
